// File: rtl/traffic_light_intersection.sv
// Two-approach crossroads controller: tick prescaler, NS/EW phases with all-red clearance,
// latched pedestrian request that can shorten NS green. Optional flashing-yellow mode under TLC_FLASH_EN.
module traffic_light_intersection #(
  parameter int CLK_DIV         = 100000000,
  parameter int NS_GREEN_TICKS  = 6,
  parameter int EW_GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS    = 2,
  parameter int ALLRED_TICKS    = 1,
  parameter int MIN_GREEN_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
`ifdef TLC_FLASH_EN
  input  logic       flash,
`endif
  input  logic       ped_req,
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       ew_green,
  output logic       ew_yellow,
  output logic       ew_red,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_GA = (NS_GREEN_TICKS > EW_GREEN_TICKS) ? NS_GREEN_TICKS : EW_GREEN_TICKS;
  localparam int MAX_YA = (YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS;
  localparam int MAX_T  = (MAX_GA > MAX_YA) ? MAX_GA : MAX_YA;
  localparam int PH_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  NS_LAST     = PH_W'(NS_GREEN_TICKS - 1);
  localparam logic [PH_W-1:0]  EW_LAST     = PH_W'(EW_GREEN_TICKS - 1);
  localparam logic [PH_W-1:0]  YEL_LAST    = PH_W'(YELLOW_TICKS - 1);
  localparam logic [PH_W-1:0]  AR_LAST     = PH_W'(ALLRED_TICKS - 1);
  localparam logic [PH_W-1:0]  MIN_GR_LAST = PH_W'(MIN_GREEN_TICKS - 1);

  localparam logic [2:0] S_ALLRED_B  = 3'd0;
  localparam logic [2:0] S_NS_GREEN  = 3'd1;
  localparam logic [2:0] S_NS_YELLOW = 3'd2;
  localparam logic [2:0] S_ALLRED_A  = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
`ifdef TLC_FLASH_EN
  localparam logic [2:0] S_FLASH     = 3'd6;
`endif

  logic [2:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic             tick;

  assign tick = (pre_cnt_q == PRE_LAST);

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
    ph_cnt_d      = ph_cnt_q;
    ped_pending_d = ped_pending_q | ped_req;
    if (tick) begin
      ph_cnt_d = ph_cnt_q + 1'b1;
      case (state_q)
        S_ALLRED_B:  if (ph_cnt_q == AR_LAST) state_d = S_NS_GREEN;
        S_NS_GREEN:  if ((ph_cnt_q == NS_LAST) || (ped_pending_q && (ph_cnt_q >= MIN_GR_LAST)))
                       state_d = S_NS_YELLOW;
        S_NS_YELLOW: if (ph_cnt_q == YEL_LAST) state_d = S_ALLRED_A;
        S_ALLRED_A:  if (ph_cnt_q == AR_LAST) state_d = S_EW_GREEN;
        S_EW_GREEN:  if (ph_cnt_q == EW_LAST) state_d = S_EW_YELLOW;
        S_EW_YELLOW: if (ph_cnt_q == YEL_LAST) state_d = S_ALLRED_B;
        default:     state_d = S_ALLRED_B;
      endcase
    end
`ifdef TLC_FLASH_EN
    // Flash overrides the normal sequence from any state; ph_cnt keeps running inside FLASH
    if (flash) state_d = S_FLASH;
    else if (state_q == S_FLASH) state_d = S_ALLRED_B;
`endif
    if (state_d != state_q) ph_cnt_d = '0;
    // Entering EW green serves the request; clear beats a same-cycle set
    if ((state_d == S_EW_GREEN) && (state_q != S_EW_GREEN)) ped_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ALLRED_B;
      pre_cnt_q     <= '0;
      ph_cnt_q      <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      ph_cnt_q      <= ph_cnt_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    ns_green  = (state_q == S_NS_GREEN);
    ns_yellow = (state_q == S_NS_YELLOW);
    ns_red    = !(ns_green || ns_yellow);
    ew_green  = (state_q == S_EW_GREEN);
    ew_yellow = (state_q == S_EW_YELLOW);
    ew_red    = !(ew_green || ew_yellow);
    walk      = ew_green;
`ifdef TLC_FLASH_EN
    // Yellows start lit on entry (ph_cnt cleared) and toggle with each tick
    if (state_q == S_FLASH) begin
      ns_yellow = ~ph_cnt_q[0];
      ew_yellow = ~ph_cnt_q[0];
      ns_red    = 1'b0;
      ew_red    = 1'b0;
    end
`endif
  end

  assign ped_pending = ped_pending_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Directed bench for traffic_light_intersection with CLK_DIV=4; flash scenario only when TLC_FLASH_EN is defined.
module tb_traffic_light_intersection;

  logic       clk = 1'b0;
  logic       reset;
  logic       ped_req;
`ifdef TLC_FLASH_EN
  logic       flash;
`endif
  logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_pending;
  logic [2:0] phase;
  logic [9:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  traffic_light_intersection #(
    .CLK_DIV(4), .NS_GREEN_TICKS(6), .EW_GREEN_TICKS(4),
    .YELLOW_TICKS(2), .ALLRED_TICKS(1), .MIN_GREEN_TICKS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef TLC_FLASH_EN
    .flash(flash),
`endif
    .ped_req(ped_req),
    .ns_green(ns_green),
    .ns_yellow(ns_yellow),
    .ns_red(ns_red),
    .ew_green(ew_green),
    .ew_yellow(ew_yellow),
    .ew_red(ew_red),
    .walk(walk),
    .ped_pending(ped_pending),
    .phase(phase)
  );

  assign obs = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, phase};

  // Expected {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase} for a normal-sequence phase
  function automatic logic [9:0] exp_lamps(input int ph);
    logic ng, ny, eg, ey;
    ng = (ph == 1);
    ny = (ph == 2);
    eg = (ph == 4);
    ey = (ph == 5);
    return {ng, ny, !(ng || ny), eg, ey, !(eg || ey), eg, 3'(ph)};
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (obs !== exp_lamps(0)) begin
      tests_failed++;
      $display("FAIL reset_lamps got %b expected %b", obs, exp_lamps(0));
    end
    tests_run++;
    if (ped_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ped_pending got %b expected 0", ped_pending);
    end
    reset = 1'b0;
  endtask

  task automatic test_normal_cycle();
    int ph[13]  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    int len[13] = '{3, 24, 8, 4, 16, 8, 4, 24, 8, 4, 16, 8, 4};
    int n = 0;
    for (int s = 0; s < 13; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        @(negedge clk);
        tests_run++;
        if (obs !== exp_lamps(ph[s])) begin
          tests_failed++;
          $display("FAIL normal_cycle n=%0d got %b expected %b", n, obs, exp_lamps(ph[s]));
        end
        n++;
      end
    end
    tests_run++;
    if (ped_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL normal_ped_pending got %b expected 0", ped_pending);
    end
  endtask

  task automatic test_ped_early();
    int ph[6]  = '{1, 2, 3, 4, 5, 0};
    int len[6] = '{8, 8, 4, 16, 8, 4};
    int n = 0;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        @(negedge clk);
        ped_req = (n == 0);
        tests_run++;
        if (obs !== exp_lamps(ph[s])) begin
          tests_failed++;
          $display("FAIL ped_early n=%0d got %b expected %b", n, obs, exp_lamps(ph[s]));
        end
        if (n == 1 || n == 19 || n == 20) begin
          tests_run++;
          if (ped_pending !== (n != 20)) begin
            tests_failed++;
            $display("FAIL ped_early_pending n=%0d got %b expected %b", n, ped_pending, (n != 20));
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_ped_late();
    int ph[6]  = '{1, 2, 3, 4, 5, 0};
    int len[6] = '{24, 8, 4, 16, 8, 4};
    int n = 0;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        @(negedge clk);
        ped_req = (n == 20);
        tests_run++;
        if (obs !== exp_lamps(ph[s])) begin
          tests_failed++;
          $display("FAIL ped_late n=%0d got %b expected %b", n, obs, exp_lamps(ph[s]));
        end
        if (n == 21 || n == 35 || n == 36) begin
          tests_run++;
          if (ped_pending !== (n != 36)) begin
            tests_failed++;
            $display("FAIL ped_late_pending n=%0d got %b expected %b", n, ped_pending, (n != 36));
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_ped_held();
    int ph[12]  = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    int len[12] = '{24, 8, 4, 16, 8, 4, 8, 8, 4, 16, 8, 4};
    int n = 0;
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        @(negedge clk);
        ped_req = (n >= 32 && n <= 37);
        tests_run++;
        if (obs !== exp_lamps(ph[s])) begin
          tests_failed++;
          $display("FAIL ped_held n=%0d got %b expected %b", n, obs, exp_lamps(ph[s]));
        end
        if (n == 35 || n == 36 || n == 37 || n == 71 || n == 84) begin
          tests_run++;
          if (ped_pending !== (n != 36 && n != 84)) begin
            tests_failed++;
            $display("FAIL ped_held_pending n=%0d got %b expected %b", n, ped_pending,
                     (n != 36 && n != 84));
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_mid_reset();
    int ph[5]  = '{1, 2, 3, 4, 5};
    int len[5] = '{24, 8, 4, 16, 2};
    int n = 0;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        @(negedge clk);
        ped_req = (n == 45);
        tests_run++;
        if (obs !== exp_lamps(ph[s])) begin
          tests_failed++;
          $display("FAIL mid_reset_run n=%0d got %b expected %b", n, obs, exp_lamps(ph[s]));
        end
        n++;
      end
    end
    tests_run++;
    if (ped_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_pre_pending got %b expected 1", ped_pending);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (obs !== exp_lamps(0)) begin
      tests_failed++;
      $display("FAIL mid_reset_lamps got %b expected %b", obs, exp_lamps(0));
    end
    tests_run++;
    if (ped_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_pending got %b expected 0", ped_pending);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_lamps((i < 3) ? 0 : 1)) begin
        tests_failed++;
        $display("FAIL mid_reset_release i=%0d got %b expected %b", i, obs, exp_lamps((i < 3) ? 0 : 1));
      end
    end
  endtask

`ifdef TLC_FLASH_EN
  task automatic test_flash();
    logic       y;
    logic [9:0] e;
    // Entered at the first NS green sample; prescaler is at 0 there
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_lamps(1)) begin
        tests_failed++;
        $display("FAIL flash_pre i=%0d got %b expected %b", i, obs, exp_lamps(1));
      end
    end
    flash = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      y = ((k / 4) % 2 == 0);
      e = {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b0, 3'd6};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL flash_toggle k=%0d got %b expected %b", k, obs, e);
      end
    end
    flash = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_lamps((i < 4) ? 0 : 1)) begin
        tests_failed++;
        $display("FAIL flash_exit i=%0d got %b expected %b", i, obs, exp_lamps((i < 4) ? 0 : 1));
      end
    end
  endtask
`endif

  initial begin
`ifdef TLC_FLASH_EN
    flash = 1'b0;
`endif
    test_reset();
    test_normal_cycle();
    test_ped_early();
    test_ped_late();
    test_ped_held();
    test_mid_reset();
`ifdef TLC_FLASH_EN
    test_flash();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/traffic_light_intersection.md
Name: traffic_light_intersection

Overview:
Parametrised two-approach traffic controller for one crossroads: main road (NS) and side road (EW).
- Fixed-length phases are counted in ticks from an internal clock prescaler, not in raw clock cycles.
- Adds an all-red clearance phase, a latched pedestrian request that can end the NS green early, and a pedestrian walk output.
- Top-level drives lamp outputs directly; one instance per intersection.

Parameters:
CLK_DIV, 100000000, clk cycles per tick (>=1); tick = 1 s at 100 MHz
NS_GREEN_TICKS, 6, NS green duration in ticks (>=1)
EW_GREEN_TICKS, 4, EW green / walk duration in ticks (>=1)
YELLOW_TICKS, 2, yellow duration for both roads (>=1)
ALLRED_TICKS, 1, all-red clearance duration (>=1)
MIN_GREEN_TICKS, 2, minimum NS green before a pedestrian request may end it (1..NS_GREEN_TICKS)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ped_req  input  1  pedestrian button, level or pulse, sampled every clk
ns_green  output  1  NS green lamp
ns_yellow  output  1  NS yellow lamp
ns_red  output  1  NS red lamp
ew_green  output  1  EW green lamp
ew_yellow  output  1  EW yellow lamp
ew_red  output  1  EW red lamp
walk  output  1  pedestrian walk across NS
ped_pending  output  1  request latched, not yet served
phase  output  3  encoded current state, for debug/LEDs

Behaviour:
- One clock domain and one synchronous active-high reset, as fixed for this block. Counter widths are $clog2 of the largest terminal value; no 100-bit counters.
- Prescaler pre_cnt counts 0..CLK_DIV-1 and wraps. tick is high for one cycle when pre_cnt==CLK_DIV-1. With CLK_DIV=1, tick is high every cycle.
- Phase counter ph_cnt increments on tick and clears on every state change.
- States and phase encoding: ALLRED_B=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_A=3, EW_GREEN=4, EW_YELLOW=5.
- Transitions are evaluated only on a tick cycle with terminal ph_cnt; the state register updates at that edge.
  - ALLRED_B -> NS_GREEN at ph_cnt==ALLRED_TICKS-1.
  - NS_GREEN -> NS_YELLOW at ph_cnt==NS_GREEN_TICKS-1, or early when ped_pending && ph_cnt>=MIN_GREEN_TICKS-1.
  - NS_YELLOW -> ALLRED_A at ph_cnt==YELLOW_TICKS-1.
  - ALLRED_A -> EW_GREEN at ph_cnt==ALLRED_TICKS-1.
  - EW_GREEN -> EW_YELLOW at ph_cnt==EW_GREEN_TICKS-1.
  - EW_YELLOW -> ALLRED_B at ph_cnt==YELLOW_TICKS-1.
- Outputs are Moore outputs decoded from the registered state only.
  - Exactly one lamp per road is high at all times.
  - ns_green=NS_GREEN, ns_yellow=NS_YELLOW, ns_red otherwise.
  - ew_green=EW_GREEN, ew_yellow=EW_YELLOW, ew_red otherwise.
  - walk=EW_GREEN.
  - Green on both roads simultaneously is impossible by construction.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge that enters EW_GREEN; clear wins over a simultaneous set.
  - ped_req asserted during EW_GREEN sets it again for the next cycle.
- Reset (at start or mid-operation):
  - state=ALLRED_B, pre_cnt=0, ph_cnt=0, ped_pending=0.
  - Outputs: ns_red=ew_red=1, all other lamps=0, walk=0, phase=0.
  - First NS_GREEN after reset release comes ALLRED_TICKS*CLK_DIV cycles later.
- Without a pedestrian request, one full cycle is (ALLRED*2 + NS_GREEN + EW_GREEN + 2*YELLOW) * CLK_DIV clk cycles.

Optional Feature:
TLC_FLASH_EN:
- Defined:
  - Adds input port flash (1 bit) and state FLASH (phase=6).
  - flash=1 sampled on any cycle forces FLASH at the next edge, from any state. Entry clears ph_cnt; ped_pending is held.
  - In FLASH, ns_yellow and ew_yellow toggle together on each tick. They start at 1 on entry. All other lamps and walk are 0.
  - flash=0 while in FLASH -> ALLRED_B at the next edge with ph_cnt cleared.
  - reset overrides flash.
- Undefined: no flash port, no FLASH state; behaviour exactly as above.

Test Plan:
(Params for all: CLK_DIV=4, NS_GREEN=6, EW_GREEN=4, YELLOW=2, ALLRED=1, MIN_GREEN=2.)
- Reset 3 cycles then release, ped_req=0 -> all red for 4 cycles; NS green 24, NS yellow 8, all red 4, EW green+walk 16, EW yellow 8, all red 4; period 64 cycles, repeats.
- ped_req 1-cycle pulse in first tick of NS_GREEN -> ped_pending=1 next cycle; NS yellow starts after 8 cycles of green (2 ticks), not 24; ped_pending=0 on the cycle EW_GREEN/walk begin.
- ped_req pulse in last tick of NS_GREEN -> no change to the 24-cycle green; request served in the following EW_GREEN.
- ped_req held high across EW_GREEN entry -> pending clears at entry, re-sets one cycle later, next NS green lasts 8 cycles.
- reset asserted mid EW_YELLOW for 1 cycle -> next cycle all red, phase=0, ped_pending=0; NS green 4 cycles after release.
- (TLC_FLASH_EN) flash=1 during NS_GREEN -> next cycle both yellows=1, toggling every 4 cycles, walk=0; flash=0 -> ALLRED_B then NS green after 4 cycles.
